// File: rtl/onfi_op_scheduler.sv
// Round-robin arbiter that runs one NAND operation at a time on the shared ONFI engine.
// After the bus phase it polls status (0x70) until RDY, a FAIL result or the poll limit.
`timescale 1ns/1ps
module onfi_op_scheduler #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned POLL_GAP  = 16,
  parameter int unsigned MAX_POLLS = 1024
) (
  input  logic                   onfi_clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*8-1:0]   req_cmd,
  input  logic [NUM_REQ*32-1:0]  req_addr,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic                   fail,
  output logic                   timeout,
  output logic [7:0]             status,
  output logic                   onfi_cen,
  output logic                   eng_start,
  output logic [7:0]             eng_cmd,
  output logic [31:0]            eng_addr,
  input  logic                   eng_done,
  output logic                   st_start,
  input  logic                   st_done,
  input  logic [7:0]             st_data
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned PW    = $clog2(MAX_POLLS + 1);
  localparam int unsigned GW    = $clog2(POLL_GAP + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ARB, S_ISSUE, S_WAIT_ENG, S_GAP, S_POLL, S_WAIT_ST, S_EVAL, S_FIN
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_idx;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_done;
  logic               r_fail;
  logic               r_timeout;
  logic [7:0]         r_status;
  logic               r_cen;
  logic               r_eng_start;
  logic [7:0]         r_eng_cmd;
  logic [31:0]        r_eng_addr;
  logic               r_st_start;
  logic [PW-1:0]      r_polls;
  logic [GW-1:0]      r_gap;

  logic               w_sel_valid;
  logic [IDX_W-1:0]   w_sel_idx;
  logic [IDX_W-1:0]   w_cand;

  // First requester found scanning upward from the one after the last grant.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_idx   = '0;
    w_cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand = IDX_W'((32'(r_ptr) + 32'(1) + k) % NUM_REQ);
      if (!w_sel_valid && req[w_cand]) begin
        w_sel_valid = 1'b1;
        w_sel_idx   = w_cand;
      end
    end
  end

  always_ff @(posedge onfi_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= IDX_W'(NUM_REQ - 1);
      r_idx       <= '0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_fail      <= 1'b0;
      r_timeout   <= 1'b0;
      r_status    <= '0;
      r_cen       <= 1'b1;
      r_eng_start <= 1'b0;
      r_eng_cmd   <= '0;
      r_eng_addr  <= '0;
      r_st_start  <= 1'b0;
      r_polls     <= '0;
      r_gap       <= '0;
    end else begin
      r_eng_start <= 1'b0;
      r_st_start  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|req) r_state <= S_ARB;
        end
        S_ARB: begin
          if (w_sel_valid) begin
            r_idx              <= w_sel_idx;
            r_ptr              <= w_sel_idx;
            r_gnt              <= '0;
            r_gnt[w_sel_idx]   <= 1'b1;
            r_cen              <= 1'b0;
            r_eng_cmd          <= req_cmd[8*w_sel_idx +: 8];
            r_eng_addr         <= req_addr[32*w_sel_idx +: 32];
            r_state            <= S_ISSUE;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          r_eng_start <= 1'b1;
          r_state     <= S_WAIT_ENG;
        end
        S_WAIT_ENG: begin
          if (eng_done) begin
            r_polls <= '0;
            r_gap   <= '0;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_gap != GW'(POLL_GAP)) r_gap <= r_gap + GW'(1);
          if (r_gap + GW'(1) == GW'(POLL_GAP)) r_state <= S_POLL;
        end
        S_POLL: begin
          r_st_start <= 1'b1;
          if (r_polls != PW'(MAX_POLLS)) r_polls <= r_polls + PW'(1);
          r_state    <= S_WAIT_ST;
        end
        S_WAIT_ST: begin
          if (st_done) begin
            r_status <= st_data;
            r_state  <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (r_status[6] || (r_polls == PW'(MAX_POLLS))) begin
            // Outputs of the done cycle are registered here so they appear with FIN.
            r_fail        <= r_status[6] & r_status[0];
            r_timeout     <= ~r_status[6];
            r_done        <= '0;
            r_done[r_idx] <= 1'b1;
            r_gnt         <= '0;
            r_cen         <= 1'b1;
            r_state       <= S_FIN;
          end else begin
            r_gap   <= '0;
            r_state <= S_GAP;
          end
        end
        S_FIN: begin
          r_done    <= '0;
          r_fail    <= 1'b0;
          r_timeout <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign done      = r_done;
  assign fail      = r_fail;
  assign timeout   = r_timeout;
  assign status    = r_status;
  assign onfi_cen  = r_cen;
  assign eng_start = r_eng_start;
  assign eng_cmd   = r_eng_cmd;
  assign eng_addr  = r_eng_addr;
  assign st_start  = r_st_start;

endmodule

// File: tb/tb_onfi_op_scheduler.sv
// Randomized bench for onfi_op_scheduler: engine/status responders plus an operation-level model
// that predicts grant order, poll count and the final fail/timeout/status of each operation.
`timescale 1ns/1ps
module tb_onfi_op_scheduler;
  localparam int N    = 4;
  localparam int GAP  = 3;
  localparam int MAXP = 4;

  logic            onfi_clk = 1'b0;
  logic            rst_n    = 1'b0;
  logic [N-1:0]    req;
  logic [N*8-1:0]  req_cmd;
  logic [N*32-1:0] req_addr;
  logic [N-1:0]    gnt, done;
  logic            fail, timeout, onfi_cen, eng_start, st_start;
  logic [7:0]      status, eng_cmd, st_data;
  logic [31:0]     eng_addr;
  logic            eng_done, st_done;

  onfi_op_scheduler #(.NUM_REQ(N), .POLL_GAP(GAP), .MAX_POLLS(MAXP)) dut (
    .onfi_clk(onfi_clk), .rst_n(rst_n), .req(req), .req_cmd(req_cmd), .req_addr(req_addr),
    .gnt(gnt), .done(done), .fail(fail), .timeout(timeout), .status(status),
    .onfi_cen(onfi_cen), .eng_start(eng_start), .eng_cmd(eng_cmd), .eng_addr(eng_addr),
    .eng_done(eng_done), .st_start(st_start), .st_done(st_done), .st_data(st_data)
  );

  always #5 onfi_clk = ~onfi_clk;

  int cyc_cnt = 0;
  always @(posedge onfi_clk) cyc_cnt <= cyc_cnt + 1;

  int n_checks = 0;
  int n_errors = 0;
  int mdl_ptr;
  logic [7:0] seq[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge onfi_clk);
    #1;
  endtask

  function automatic logic [7:0] seq_at(input int k);
    return seq[(k < seq.size()) ? k : seq.size() - 1];
  endfunction

  task automatic randomize_reqs();
    for (int i = 0; i < N; i++) begin
      req_cmd[8*i +: 8]   = 8'($urandom);
      req_addr[32*i +: 32] = $urandom;
    end
  endtask

  // One complete operation; bench is sampled 1ns after each rising edge.
  task automatic run_op(input logic [N-1:0] mask, input logic [N-1:0] next_mask,
                        input bit drop_req, input bit strays, input int eng_dly);
    int exp_idx, exp_polls, polls, cyc, mark, c;
    bit exp_to, exp_fail, got_done;
    logic [7:0] exp_status, exp_cmd;
    logic [31:0] exp_addr;

    exp_idx = -1;
    for (int k = 1; k <= N; k++) begin
      c = (mdl_ptr + k) % N;
      if (exp_idx < 0 && mask[c]) exp_idx = c;
    end
    exp_status = 8'h00;
    exp_polls  = 0;
    for (int k = 0; k < MAXP; k++) begin
      exp_status = seq_at(k);
      exp_polls  = k + 1;
      if (exp_status[6]) break;
    end
    exp_to   = !exp_status[6];
    exp_fail = exp_status[6] && exp_status[0];
    exp_cmd  = req_cmd[8*exp_idx +: 8];
    exp_addr = req_addr[32*exp_idx +: 32];

    req = mask;
    cyc = 0;
    while (gnt == '0 && cyc < 20) begin tick(); cyc++; end
    check_eq("gnt", 32'(gnt), 32'(1) << exp_idx);
    check_eq("cen_low_at_gnt", 32'(onfi_cen), 0);
    tick();
    check_eq("eng_start_after_gnt", 32'(eng_start), 1);
    cyc = 0;
    while (!eng_start && cyc < 10) begin tick(); cyc++; end
    check_eq("eng_cmd", 32'(eng_cmd), 32'(exp_cmd));
    check_eq("eng_addr", eng_addr, exp_addr);
    randomize_reqs();
    if (drop_req) req = '0;

    repeat ((eng_dly > 0) ? eng_dly : $urandom_range(1, 4)) tick();
    check_eq("eng_cmd_stable", 32'(eng_cmd), 32'(exp_cmd));
    eng_done = 1'b1;
    mark = cyc_cnt;
    tick();
    eng_done = 1'b0;
    if (strays) begin
      st_data  = 8'($urandom) | 8'h40;
      st_done  = 1'b1;
      eng_done = 1'b1;
      tick();
      st_done  = 1'b0;
      eng_done = 1'b0;
    end

    polls = 0;
    got_done = 1'b0;
    cyc = 0;
    while (!got_done && cyc < 300) begin
      if (st_start) begin
        polls++;
        check_eq("poll_spacing", 32'(cyc_cnt - mark >= GAP + 1), 1);
        mark = cyc_cnt;
        repeat ($urandom_range(1, 3)) tick();
        st_data = seq_at(polls - 1);
        st_done = 1'b1;
        tick();
        st_done = 1'b0;
        st_data = 8'($urandom);
        cyc += 2;
      end else if (done != '0) begin
        got_done = 1'b1;
      end else begin
        tick();
        cyc++;
      end
    end
    check_eq("done_seen", 32'(got_done), 1);
    check_eq("done_idx", 32'(done), 32'(1) << exp_idx);
    check_eq("poll_count", polls, exp_polls);
    check_eq("fail", 32'(fail), 32'(exp_fail));
    check_eq("timeout", 32'(timeout), 32'(exp_to));
    check_eq("status", 32'(status), 32'(exp_status));
    check_eq("cen_high_at_done", 32'(onfi_cen), 1);
    check_eq("gnt_clear_at_done", 32'(gnt), 0);
    mdl_ptr = exp_idx;
    req = next_mask;
    tick();
    check_eq("done_one_cycle", 32'(done), 0);
    check_eq("cen_gap1", 32'(onfi_cen), 1);
    tick();
    check_eq("cen_gap2", 32'(onfi_cen), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_gnt"}, 32'(gnt), 0);
    check_eq({tag, "_done"}, 32'(done), 0);
    check_eq({tag, "_cen"}, 32'(onfi_cen), 1);
    check_eq({tag, "_eng_start"}, 32'(eng_start), 0);
    check_eq({tag, "_st_start"}, 32'(st_start), 0);
    check_eq({tag, "_fail"}, 32'(fail), 0);
    check_eq({tag, "_timeout"}, 32'(timeout), 0);
    check_eq({tag, "_status"}, 32'(status), 0);
    check_eq({tag, "_eng_cmd"}, 32'(eng_cmd), 0);
    check_eq({tag, "_eng_addr"}, eng_addr, 0);
  endtask

  initial begin
    int cyc;
    logic [N-1:0] m, nm;
    req = '0; eng_done = 1'b0; st_done = 1'b0; st_data = '0;
    req_cmd = '0; req_addr = '0;
    mdl_ptr = N - 1;
    randomize_reqs();

    repeat (3) @(posedge onfi_clk);
    #1;
    check_reset_outputs("reset");
    @(negedge onfi_clk) rst_n = 1'b1;
    tick();

    eng_done = 1'b1; st_done = 1'b1; st_data = 8'h40;
    tick();
    eng_done = 1'b0; st_done = 1'b0;
    repeat (3) begin
      tick();
      check_eq("idle_stray_gnt", 32'(gnt), 0);
      check_eq("idle_stray_st_start", 32'(st_start), 0);
      check_eq("idle_stray_eng_start", 32'(eng_start), 0);
    end

    req_cmd[7:0] = 8'h60; req_addr[31:0] = 32'h0000_1234;
    seq = {8'h40};
    run_op(4'b0001, 4'b0001, 1'b0, 1'b0, 5);

    seq = {8'h00, 8'h00, 8'h41};
    run_op(4'b0001, 4'b1111, 1'b0, 1'b1, 0);

    seq = {8'h40};
    for (int i = 0; i < 5; i++) run_op(4'b1111, (i == 4) ? 4'b0000 : 4'b1111, 1'b0, 1'b0, 0);

    seq = {8'h00};
    run_op(4'b0100, 4'b0000, 1'b0, 1'b1, 0);

    m = 4'($urandom_range(1, 15));
    for (int i = 0; i < 24; i++) begin
      seq.delete();
      repeat ($urandom_range(1, 6)) seq.push_back((8'($urandom) & 8'hBF) | (($urandom_range(0, 3) == 0) ? 8'h40 : 8'h00));
      nm = 4'($urandom_range(1, 15));
      run_op(m, nm, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      m = nm;
    end

    // Abort an operation while the status read is outstanding.
    req = '0;
    repeat (4) tick();
    req = 4'b0010;
    cyc = 0;
    while (!eng_start && cyc < 20) begin tick(); cyc++; end
    check_eq("midop_gnt", 32'(gnt), 32'h2);
    tick();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    cyc = 0;
    while (!st_start && cyc < 40) begin tick(); cyc++; end
    check_eq("midop_st_start_seen", 32'(st_start), 1);
    rst_n = 1'b0;
    req = '0;
    #1;
    check_reset_outputs("midop_reset");
    repeat (2) @(posedge onfi_clk);
    @(negedge onfi_clk) rst_n = 1'b1;
    mdl_ptr = N - 1;
    tick();
    seq = {8'h40};
    run_op(4'b0101, 4'b0000, 1'b0, 1'b0, 0);
    run_op(4'b0100, 4'b0000, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
